inst_mem_ctrl: RTL

- Parametrised instruction memory with a boot-load session FSM, a handshaked fetch port and a byte-enabled debug patch port.
- Sits between the external loader (UART/JTAG bridge) and the core's IF stage.
- Read latency is one registered cycle. Misaligned and out-of-range fetches are flagged.
- Successor to the single-width, combinational-read instruction RAM.

---
 rtl/inst_mem_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: boot-load session FSM, handshaked fetch port with a
// one-cycle registered read, and a byte-enabled debug patch port.
// Optional macro INST_MEM_PARITY_EN adds per-word even parity and the rsp_perr output.
module inst_mem_ctrl #(
    parameter int unsigned  W         = 32,
    parameter int unsigned  H         = 8,
    parameter logic [W-1:0] BASE_ADDR = '0,
    parameter logic [W-1:0] NOP_INST  = W'(32'h00000013)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_start,
    input  logic           load_valid,
    input  logic [W-1:0]   load_data,
    input  logic           load_last,
    output logic           load_ready,
    output logic           load_done,
    input  logic           fetch_req,
    input  logic [W-1:0]   fetch_pc,
    output logic           fetch_gnt,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_inst,
    output logic [W-1:0]   rsp_pc,
    output logic           rsp_fault,
`ifdef INST_MEM_PARITY_EN
    output logic           rsp_perr,
`endif
    input  logic           flush,
    input  logic           dbg_wr,
    input  logic [W-1:0]   dbg_addr,
    input  logic [W-1:0]   dbg_data,
    input  logic [W/8-1:0] dbg_be
);

    localparam int unsigned  Depth  = 2 ** H;
    localparam int unsigned  NB     = W / 8;
    localparam logic [W-1:0] DepthW = W'(Depth);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } state_e;

    state_e         state_q;
    logic [H-1:0]   ptr_q;
    logic [W-1:0]   mem [Depth];

    logic           run;
    logic           load_we;
    logic [W-1:0]   fetch_off;
    logic           fetch_fault;
    logic [H-1:0]   fetch_idx;
    logic [W-1:0]   fetch_word;
    logic [W-1:0]   dbg_off;
    logic           dbg_we;
    logic [H-1:0]   dbg_idx;
    logic [W-1:0]   dbg_merged;
    logic           dbg_hit;

    assign run        = (state_q == StRun);
    assign load_ready = (state_q == StLoad);
    assign load_done  = run;

    // A beat arriving together with load_start is dropped.
    assign load_we = load_ready & load_valid & ~load_start;

    // Index math is in W bits; a wrapped subtraction is caught by the below-base test.
    assign fetch_off   = fetch_pc - BASE_ADDR;
    assign fetch_fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc < BASE_ADDR) ||
                         ((fetch_off >> 2) >= DepthW);
    assign fetch_idx   = fetch_off[H+1:2];

    assign dbg_off = dbg_addr - BASE_ADDR;
    assign dbg_we  = run & dbg_wr & (dbg_addr[1:0] == 2'b00) & ~(dbg_addr < BASE_ADDR) &
                     ((dbg_off >> 2) < DepthW);
    assign dbg_idx = dbg_off[H+1:2];
    assign dbg_hit = dbg_we & (dbg_idx == fetch_idx);

    assign fetch_gnt = run & fetch_req & ~flush & (~rsp_valid | rsp_ready);

    // Byte-merge the patch into the current word.
    always_comb begin
        dbg_merged = mem[dbg_idx];
        for (int unsigned b = 0; b < NB; b++) begin
            if (dbg_be[b]) begin
                dbg_merged[8*b +: 8] = dbg_data[8*b +: 8];
            end
        end
    end

    // Write-first: a same-cycle patch of the fetched word is forwarded.
    assign fetch_word = dbg_hit ? dbg_merged : mem[fetch_idx];

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[ptr_q] <= load_data;
        end else if (dbg_we) begin
            mem[dbg_idx] <= dbg_merged;
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic mem_par [Depth];
    logic fetch_par;
    logic perr_d;

    assign fetch_par = dbg_hit ? ^dbg_merged : mem_par[fetch_idx];
    assign perr_d    = (^fetch_word) ^ fetch_par;

    // Even parity over the final stored word.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_par[ptr_q] <= ^load_data;
        end else if (dbg_we) begin
            mem_par[dbg_idx] <= ^dbg_merged;
        end
    end

    // Parity error travels with the response and holds during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_perr <= 1'b0;
        end else if (fetch_gnt) begin
            rsp_perr <= fetch_fault ? 1'b0 : perr_d;
        end
    end
`endif

    // Load session FSM; reset mid-session aborts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_start) begin
                        state_q <= StLoad;
                        ptr_q   <= '0;
                    end
                end
                StLoad: begin
                    if (load_start) begin
                        ptr_q <= '0;
                    end else if (load_valid) begin
                        ptr_q <= ptr_q + H'(1);
                        // Filling the last word ends the session even without load_last.
                        if (load_last || (ptr_q == {H{1'b1}})) begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (load_start) begin
                        state_q <= StLoad;
                        ptr_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Response register; payload only changes on accept so it is stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_inst  <= '0;
            rsp_pc    <= '0;
            rsp_fault <= 1'b0;
        end else begin
            if (fetch_gnt) begin
                rsp_valid <= 1'b1;
                rsp_pc    <= fetch_pc;
                rsp_inst  <= fetch_fault ? NOP_INST : fetch_word;
                rsp_fault <= fetch_fault;
            end else if (flush || rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // Reopening a load session drops anything pending.
            if (run && load_start) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
